// File: rtl/uart_pkg.sv
// Shared UART constants: receiver state encoding, line levels, parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam int   MAX_DATA_BITS = 8;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter should have sent for this data word.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioning for uart_rx: 2-FF synchronizer, falling-edge detect and
// the two stored samples that feed the 3-sample majority vote.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  input  logic sample_i,
  output logic rx_sync_o,
  output logic fall_o,
  output logic vote_o
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_samp;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_meta <= UART_IDLE_LVL;
      r_sync <= UART_IDLE_LVL;
      r_prev <= UART_IDLE_LVL;
      r_samp <= {2{UART_IDLE_LVL}};
    end else begin
      r_meta <= rx_i;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (sample_i) r_samp <= {r_samp[0], r_sync};
    end
  end

  assign rx_sync_o = r_sync;
  assign fall_o    = r_prev & ~r_sync;
  // Third sample is the live synchronized level at the decision tick.
  assign vote_o    = maj3(r_samp[1], r_samp[0], r_sync);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: FSM, tick/bit counters and shift register.
// Emits one-cycle byte, parity-error and framing-error strobes plus a break level.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMP_RATE = 16,
  parameter int DATA_BITS     = 8,
  parameter bit PARITY_EN     = 1'b0,
  parameter bit PARITY_ODD    = 1'b0,
  parameter int STOP_BITS     = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     enable_i,
  input  logic                     clk16_en_i,
  input  logic                     rx_i,
  output logic                     rx_datavld_o,
  output logic [MAX_DATA_BITS-1:0] rx_data_o,
  output logic                     frame_err_o,
  output logic                     parity_err_o,
  output logic                     break_o,
  output logic                     busy_o
);

  if (OVERSAMP_RATE < 8 || (OVERSAMP_RATE % 2) != 0) begin : g_bad_os
    $error("uart_rx: OVERSAMP_RATE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_db
    $error("uart_rx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_rx: STOP_BITS must be 1 or 2");
  end

  localparam int             TW        = $clog2(OVERSAMP_RATE);
  localparam int             MID       = OVERSAMP_RATE / 2;
  localparam logic [TW-1:0]  TICK_PRE  = TW'(MID - 1);
  localparam logic [TW-1:0]  TICK_MID  = TW'(MID);
  localparam logic [TW-1:0]  TICK_POST = TW'(MID + 1);
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMP_RATE - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);

  rx_state_t                r_state;
  logic [TW-1:0]            r_tick;
  logic [2:0]               r_bitcnt;
  logic [DATA_BITS-1:0]     r_shift;
  logic                     r_par_err;
  logic                     r_datavld;
  logic [MAX_DATA_BITS-1:0] r_data;
  logic                     r_frame_err;
  logic                     r_parity_err;
  logic                     r_break;

  logic                     w_rx_sync;
  logic                     w_fall;
  logic                     w_vote;
  logic                     w_in_frame;
  logic                     w_sample;
  logic                     w_decide;
  logic [MAX_DATA_BITS-1:0] w_shift_ext;

  assign w_in_frame  = (r_state != ST_IDLE) && (r_state != ST_BRK_WAIT);
  assign w_sample    = clk16_en_i && w_in_frame && ((r_tick == TICK_PRE) || (r_tick == TICK_MID));
  assign w_decide    = clk16_en_i && w_in_frame && (r_tick == TICK_POST);
  assign w_shift_ext = MAX_DATA_BITS'(r_shift);

  uart_rx_sync u_sync (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rx_i      (rx_i),
    .sample_i  (w_sample),
    .rx_sync_o (w_rx_sync),
    .fall_o    (w_fall),
    .vote_o    (w_vote)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= ST_IDLE;
      r_tick       <= '0;
      r_bitcnt     <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_datavld    <= 1'b0;
      r_data       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_break      <= 1'b0;
    end else begin
      r_datavld    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      if (!enable_i) begin
        r_state  <= ST_IDLE;
        r_tick   <= '0;
        r_bitcnt <= '0;
        r_break  <= 1'b0;
      end else begin
        if (clk16_en_i && w_in_frame) r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
        case (r_state)
          ST_IDLE: begin
            if (w_fall) begin
              r_state   <= ST_START;
              r_tick    <= '0;
              r_bitcnt  <= '0;
              r_par_err <= 1'b0;
            end
          end
          ST_START: begin
            if (w_decide) r_state <= w_vote ? ST_IDLE : ST_DATA;
          end
          ST_DATA: begin
            if (w_decide) begin
              r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
              if (r_bitcnt == BIT_LAST) r_state <= PARITY_EN ? ST_PARITY : ST_STOP;
              else                      r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
          ST_PARITY: begin
            if (w_decide) begin
              r_par_err <= (w_vote != parity_bit(w_shift_ext, PARITY_ODD));
              r_state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            // Only the first stop bit is checked; a second one just looks like idle.
            if (w_decide) begin
              if (w_vote) begin
                r_datavld    <= 1'b1;
                r_data       <= w_shift_ext;
                r_parity_err <= r_par_err;
                r_state      <= ST_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                if (r_shift == '0) r_break <= 1'b1;
                r_tick      <= '0;
                r_state     <= ST_BRK_WAIT;
              end
            end
          end
          ST_BRK_WAIT: begin
            // Need a full bit time of uninterrupted idle line before rearming.
            if (clk16_en_i) begin
              if (!w_rx_sync) begin
                r_tick <= '0;
              end else if (r_tick == TICK_LAST) begin
                r_tick  <= '0;
                r_break <= 1'b0;
                r_state <= ST_IDLE;
              end else begin
                r_tick <= r_tick + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_datavld_o = r_datavld;
  assign rx_data_o    = r_data;
  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign break_o      = r_break;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance, checked against a
// frame-level model of what each transmitted frame must produce.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = OS * TICK_DIV;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         perr;
    bit         brk;
    int         wlo;
    int         whi;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en0, en1;
  logic       tick;
  logic       rx0, rx1;
  logic       vld0, fe0, pe0, brk0, busy0;
  logic       vld1, fe1, pe1, brk1, busy1;
  logic [7:0] data0, data1;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        q0[$];
  ev_t        q1[$];
  logic [7:0] hold0 = 8'h00;
  logic [7:0] hold1 = 8'h00;
  logic [7:0] cap0[$];
  bit         last_pe1 = 1'b0;

  always #5 clk = ~clk;

  uart_rx dut0 (
    .clk_i(clk), .reset_i(reset), .enable_i(en0), .clk16_en_i(tick), .rx_i(rx0),
    .rx_datavld_o(vld0), .rx_data_o(data0), .frame_err_o(fe0), .parity_err_o(pe0),
    .break_o(brk0), .busy_o(busy0)
  );

  uart_rx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk_i(clk), .reset_i(reset), .enable_i(en1), .clk16_en_i(tick), .rx_i(rx1),
    .rx_datavld_o(vld1), .rx_data_o(data1), .frame_err_o(fe1), .parity_err_o(pe1),
    .break_o(brk1), .busy_o(busy1)
  );

  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (div == TICK_DIV - 1);
      div  = (div + 1) % TICK_DIV;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%0h expected=%0h cyc=%0d", name, inst, act, exp, cyc);
    end
  endtask

  // Frame-level model: what a complete frame on the wire must produce.
  function automatic ev_t model(input logic [7:0] d, input bit par_en, input bit par_lvl,
                                input bit stop_lvl, input int stop_cyc);
    ev_t e;
    bit  ones_odd;
    ones_odd = ($countones(d) % 2) == 1;
    e.is_err = !stop_lvl;
    e.data   = d;
    e.perr   = par_en && stop_lvl && (par_lvl != ones_odd);
    e.brk    = !stop_lvl && (d == 8'h00);
    e.wlo    = stop_cyc + BIT_CLKS / 2 - 4;
    e.whi    = stop_cyc + BIT_CLKS / 2 + 20;
    return e;
  endfunction

  task automatic set_rx(input int inst, input logic v);
    if (inst == 0) rx0 = v;
    else           rx1 = v;
  endtask

  task automatic drive_bit(input int inst, input logic v, output int c);
    @(negedge clk);
    set_rx(inst, v);
    c = cyc;
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic idle(input int inst, input int nclk);
    set_rx(inst, 1'b1);
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send(input int inst, input logic [7:0] d, input bit bad_par, input bit stop_lvl);
    int  c;
    bit  par_lvl;
    ev_t e;
    par_lvl = ((($countones(d) % 2) == 1)) ^ bad_par;
    drive_bit(inst, 1'b0, c);
    for (int i = 0; i < 8; i++) drive_bit(inst, d[i], c);
    if (inst == 1) drive_bit(inst, par_lvl, c);
    @(negedge clk);
    set_rx(inst, stop_lvl);
    e = model(d, inst == 1, par_lvl, stop_lvl, cyc);
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
    repeat (BIT_CLKS - 1) @(negedge clk);
  endtask

  task automatic check_inst(input int inst);
    logic       v, fe, pe, bk;
    logic [7:0] d, hold;
    ev_t        e;
    bit         have;
    if (inst == 0) begin v = vld0; fe = fe0; pe = pe0; bk = brk0; d = data0; hold = hold0; end
    else           begin v = vld1; fe = fe1; pe = pe1; bk = brk1; d = data1; hold = hold1; end
    if (reset) return;
    have = 1'b0;
    if (v || fe) begin
      if (inst == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (inst == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      chk("strobe_expected", inst, {31'd0, have}, 32'd1);
      chk("vld_fe_exclusive", inst, {31'd0, v & fe}, 32'd0);
      if (have) begin
        chk("strobe_kind", inst, {31'd0, fe}, {31'd0, e.is_err});
        chk("strobe_window", inst, {31'd0, (cyc >= e.wlo) && (cyc <= e.whi)}, 32'd1);
        if (e.is_err) begin
          chk("break_level", inst, {31'd0, bk}, {31'd0, e.brk});
          chk("data_kept_on_ferr", inst, {24'd0, d}, {24'd0, hold});
        end else begin
          chk("data", inst, {24'd0, d}, {24'd0, e.data});
          chk("parity_err", inst, {31'd0, pe}, {31'd0, e.perr});
          hold = e.data;
        end
      end
      if (v && inst == 0) cap0.push_back(d);
      if (v && inst == 1) last_pe1 = pe;
    end else begin
      chk("data_hold", inst, {24'd0, d}, {24'd0, hold});
      chk("perr_alone", inst, {31'd0, pe}, 32'd0);
    end
    if (inst == 0) hold0 = hold;
    else           hold1 = hold;
  endtask

  initial forever begin
    @(negedge clk);
    check_inst(0);
    check_inst(1);
  end

  task automatic chk_all_zero(input int inst);
    if (inst == 0) begin
      chk("rst_vld", 0, {31'd0, vld0}, 32'd0);   chk("rst_data", 0, {24'd0, data0}, 32'd0);
      chk("rst_fe", 0, {31'd0, fe0}, 32'd0);     chk("rst_pe", 0, {31'd0, pe0}, 32'd0);
      chk("rst_brk", 0, {31'd0, brk0}, 32'd0);   chk("rst_busy", 0, {31'd0, busy0}, 32'd0);
    end else begin
      chk("rst_vld", 1, {31'd0, vld1}, 32'd0);   chk("rst_data", 1, {24'd0, data1}, 32'd0);
      chk("rst_fe", 1, {31'd0, fe1}, 32'd0);     chk("rst_pe", 1, {31'd0, pe1}, 32'd0);
      chk("rst_brk", 1, {31'd0, brk1}, 32'd0);   chk("rst_busy", 1, {31'd0, busy1}, 32'd0);
    end
  endtask

  task automatic run_random(input int inst, input int n);
    logic [7:0] d;
    int         k;
    bit         badp, stp;
    for (int i = 0; i < n; i++) begin
      d    = 8'($urandom);
      k    = int'($urandom_range(0, 9));
      badp = (inst == 1) && (k == 7 || k == 8);
      stp  = (k != 9);
      send(inst, d, badp, stp);
      if (!stp) idle(inst, 2 * BIT_CLKS);
      else      idle(inst, int'($urandom_range(0, 2)) * BIT_CLKS + int'($urandom_range(0, 40)));
    end
  endtask

  initial begin
    logic [7:0] gp[6];
    int         c;
    gp = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h47, 8'h41};
    reset = 1'b1; en0 = 1'b1; en1 = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
    repeat (5) @(negedge clk);
    chk_all_zero(0);
    chk_all_zero(1);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    send(0, 8'h24, 1'b0, 1'b1);
    idle(0, 2 * BIT_CLKS);
    chk("lit_24", 0, {24'd0, data0}, 32'h24);

    cap0.delete();
    for (int i = 0; i < 6; i++) send(0, gp[i], 1'b0, 1'b1);
    idle(0, 2 * BIT_CLKS);
    chk("gpgga_count", 0, cap0.size(), 6);
    for (int i = 0; i < 6 && i < cap0.size(); i++) chk("gpgga_byte", 0, {24'd0, cap0[i]}, {24'd0, gp[i]});

    @(negedge clk); rx0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_busy_hi", 0, {31'd0, busy0}, 32'd1);
    repeat (8) @(negedge clk); rx0 = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("glitch_busy_lo", 0, {31'd0, busy0}, 32'd0);

    send(0, 8'h55, 1'b0, 1'b0);
    idle(0, 2 * BIT_CLKS);
    chk("ferr_data_kept", 0, {24'd0, data0}, 32'h41);
    chk("ferr_no_break", 0, {31'd0, brk0}, 32'd0);

    send(0, 8'h00, 1'b0, 1'b0);
    drive_bit(0, 1'b0, c);
    drive_bit(0, 1'b0, c);
    chk("break_set", 0, {31'd0, brk0}, 32'd1);
    idle(0, BIT_CLKS / 2);
    chk("break_held", 0, {31'd0, brk0}, 32'd1);
    idle(0, BIT_CLKS / 2 + 16);
    chk("break_clear", 0, {31'd0, brk0}, 32'd0);
    chk("break_busy_lo", 0, {31'd0, busy0}, 32'd0);
    send(0, 8'h0A, 1'b0, 1'b1);
    idle(0, BIT_CLKS);
    chk("lit_0a", 0, {24'd0, data0}, 32'h0A);

    send(1, 8'h47, 1'b1, 1'b1);
    idle(1, BIT_CLKS);
    chk("lit_47_data", 1, {24'd0, data1}, 32'h47);
    chk("lit_47_perr", 1, {31'd0, last_pe1}, 32'd1);
    send(1, 8'h47, 1'b0, 1'b1);
    idle(1, BIT_CLKS);
    chk("lit_47_good", 1, {31'd0, last_pe1}, 32'd0);

    // 0xFA: bits 3..7 and stop are high, so nothing after the reset looks like a start.
    drive_bit(0, 1'b0, c);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'(8'hFA >> i), c);
    @(negedge clk); rx0 = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    reset = 1'b1; hold0 = 8'h00; hold1 = 8'h00;
    @(negedge clk); reset = 1'b0;
    chk_all_zero(0);
    idle(0, 6 * BIT_CLKS);
    send(0, 8'h41, 1'b0, 1'b1);
    idle(0, BIT_CLKS);
    chk("lit_41_after_rst", 0, {24'd0, data0}, 32'h41);

    drive_bit(0, 1'b0, c);
    drive_bit(0, 1'b1, c);
    @(negedge clk); rx0 = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    en0 = 1'b0;
    @(negedge clk);
    chk("abort_busy", 0, {31'd0, busy0}, 32'd0);
    for (int i = 0; i < 6; i++) drive_bit(0, 1'b0, c);
    drive_bit(0, 1'b1, c);
    idle(0, BIT_CLKS);
    en0 = 1'b1;
    chk("abort_data_kept", 0, {24'd0, data0}, 32'h41);
    idle(0, BIT_CLKS);
    send(0, 8'h3C, 1'b0, 1'b1);
    idle(0, BIT_CLKS);
    chk("lit_3c_after_abort", 0, {24'd0, data0}, 32'h3C);

    run_random(0, 16);
    run_random(1, 16);

    repeat (3 * BIT_CLKS) @(negedge clk);
    chk("pending_events", 0, q0.size(), 0);
    chk("pending_events", 1, q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
